// File: rtl/logo_scroll_ctrl.sv
// logo_scroll_ctrl
// ----------------
// Moves a logo offset (delt) back and forth between 0 and max_delt, one
// motion step every FRAME_DIV frame_tick pulses. At each travel end the
// offset dwells for HOLD_FRAMES motion steps (at least one) before the
// direction reverses.
//
// Optional build macro LOGO_SCROLL_WRAP_EN: rightward motion wraps around
// past max_delt instead of bouncing; the HOLD and MOVE_L states are never
// entered and dir stays 0.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   enble       in   motion enable; 0 freezes everything, bounce low
//   frame_tick  in   one-cycle pulse at start of vertical blanking
//   speed[3:0]  in   pixels per motion step (0 = no movement)
//   max_delt    in   right travel limit, sampled on motion steps only
//   delt[10:0]  out  registered horizontal offset
//   dir         out  0 = rightward, 1 = leftward
//   bounce      out  one-cycle pulse after delt reaches a travel end
//   state_o     out  FSM state: 0 MOVE_R, 1 MOVE_L, 2 HOLD_R, 3 HOLD_L
//
// Handshake: there is no valid/ready pair; frame_tick is a qualifier that
// is acted on in the cycle it is high, and bounce is a fire-and-forget
// pulse with no backpressure.
module logo_scroll_ctrl #(
  parameter int HOLD_FRAMES = 8,
  parameter int FRAME_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enble,
  input  logic        frame_tick,
  input  logic [3:0]  speed,
  input  logic [10:0] max_delt,
  output logic [10:0] delt,
  output logic        dir,
  output logic        bounce,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    MOVE_R = 2'd0,
    MOVE_L = 2'd1,
    HOLD_R = 2'd2,
    HOLD_L = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] delt_q, delt_d;
  logic        dir_q, dir_d;
  logic        bounce_q, bounce_d;
  logic [3:0]  div_q, div_d;
  logic [7:0]  hold_q, hold_d;

  logic        tick_en;
  logic        step;
  logic [11:0] sum;
  logic        hold_done;

  assign tick_en = enble && frame_tick;
  // The divider counts 0..FRAME_DIV-1; the pulse that hits the top is a step.
  assign step    = tick_en && (div_q == 4'(FRAME_DIV - 1));
  // 12-bit sum so delt+speed cannot overflow past the 11-bit range.
  assign sum     = {1'b0, delt_q} + {8'b0, speed};
  // A hold with HOLD_FRAMES=0 still spends one step, hence the +1 compare.
  assign hold_done = ({1'b0, hold_q} + 9'd1) >= 9'(HOLD_FRAMES);

`ifdef LOGO_SCROLL_WRAP_EN
  logic [11:0] wrap_val;
  assign wrap_val = sum - {1'b0, max_delt} - 12'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MOVE_R;
      delt_q   <= '0;
      dir_q    <= 1'b0;
      bounce_q <= 1'b0;
      div_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      delt_q   <= delt_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    delt_d   = delt_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
    div_d    = div_q;
    hold_d   = hold_q;

    if (tick_en) begin
      div_d = step ? 4'd0 : div_q + 4'd1;
    end

    if (step) begin
      unique case (state_q)
        MOVE_R: begin
          // speed=0 means no movement at all, even if max_delt dropped.
          if (speed != 4'd0) begin
`ifdef LOGO_SCROLL_WRAP_EN
            if (sum > {1'b0, max_delt}) begin
              delt_d   = wrap_val[10:0];
              bounce_d = 1'b1;
            end else begin
              delt_d = sum[10:0];
            end
`else
            // >= also catches max_delt having fallen below delt.
            if (sum >= {1'b0, max_delt}) begin
              delt_d   = max_delt;
              bounce_d = 1'b1;
              state_d  = HOLD_R;
              hold_d   = '0;
            end else begin
              delt_d = sum[10:0];
            end
`endif
          end
        end
        MOVE_L: begin
          if (speed != 4'd0) begin
            if (delt_q <= {7'b0, speed}) begin
              delt_d   = '0;
              bounce_d = 1'b1;
              state_d  = HOLD_L;
              hold_d   = '0;
            end else begin
              delt_d = delt_q - {7'b0, speed};
            end
          end
        end
        HOLD_R: begin
          if (hold_done) begin
            state_d = MOVE_L;
            dir_d   = ~dir_q;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        HOLD_L: begin
          if (hold_done) begin
            state_d = MOVE_R;
            dir_d   = ~dir_q;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: state_d = MOVE_R;
      endcase
    end
  end

  assign delt    = delt_q;
  assign dir     = dir_q;
  assign bounce  = bounce_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// Bench for logo_scroll_ctrl. Two instances share the same stimulus:
// u0 with HOLD_FRAMES=2, FRAME_DIV=1 and u1 with HOLD_FRAMES=0, FRAME_DIV=3.
// An offset/heading/rest model is compared with both on every cycle, and
// directed literal expectations pin the model on known sequences.
module tb_logo_scroll_ctrl;

  logic        clk;
  logic        rst;
  logic        enble;
  logic        frame_tick;
  logic [3:0]  speed;
  logic [10:0] max_delt;
  logic [10:0] delt_w [2];
  logic        dir_w [2];
  logic        bounce_w [2];
  logic [1:0]  state_w [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logo_scroll_ctrl #(.HOLD_FRAMES(2), .FRAME_DIV(1)) u0 (
    .clk(clk), .rst(rst), .enble(enble), .frame_tick(frame_tick),
    .speed(speed), .max_delt(max_delt),
    .delt(delt_w[0]), .dir(dir_w[0]), .bounce(bounce_w[0]), .state_o(state_w[0])
  );

  logo_scroll_ctrl #(.HOLD_FRAMES(0), .FRAME_DIV(3)) u1 (
    .clk(clk), .rst(rst), .enble(enble), .frame_tick(frame_tick),
    .speed(speed), .max_delt(max_delt),
    .delt(delt_w[1]), .dir(dir_w[1]), .bounce(bounce_w[1]), .state_o(state_w[1])
  );

  // ---------------- behavioural model ----------------
  // pos: offset; heading +1 right / -1 left; resting with rest_left steps
  // remaining; ticks counts frame pulses toward the next step.
  int m_pos [2];
  int m_heading [2];
  int m_resting [2];
  int m_rest_left [2];
  int m_ticks [2];
  int m_bounce [2];

  function automatic int cfg_div(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int cfg_hold(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_reset(input int i);
    m_pos[i] = 0; m_heading[i] = 1; m_resting[i] = 0;
    m_rest_left[i] = 0; m_ticks[i] = 0; m_bounce[i] = 0;
  endtask

  task automatic model_step(input int i);
    int spd, lim, target;
    spd = int'(speed);
    lim = int'(max_delt);
    if (m_resting[i] != 0) begin
      m_rest_left[i] = m_rest_left[i] - 1;
      if (m_rest_left[i] == 0) begin
        m_resting[i] = 0;
        m_heading[i] = -m_heading[i];
      end
    end else if (spd != 0) begin
      target = m_pos[i] + m_heading[i] * spd;
`ifdef LOGO_SCROLL_WRAP_EN
      if (target > lim) begin
        m_pos[i] = (target - lim - 1) % 2048;
        m_bounce[i] = 1;
      end else begin
        m_pos[i] = target;
      end
`else
      if (m_heading[i] > 0 && target >= lim) begin
        m_pos[i] = lim;
        m_bounce[i] = 1;
      end else if (m_heading[i] < 0 && target <= 0) begin
        m_pos[i] = 0;
        m_bounce[i] = 1;
      end else begin
        m_pos[i] = target;
      end
      if (m_bounce[i] != 0) begin
        m_resting[i] = 1;
        m_rest_left[i] = (cfg_hold(i) == 0) ? 1 : cfg_hold(i);
      end
`endif
    end
  endtask

  function automatic int model_state(input int i);
    if (m_resting[i] != 0) return (m_heading[i] > 0) ? 2 : 3;
    return (m_heading[i] > 0) ? 0 : 1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) model_reset(i);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        model_reset(i);
      end else begin
        m_bounce[i] = 0;
        if (enble && frame_tick) begin
          m_ticks[i] = m_ticks[i] + 1;
          if (m_ticks[i] == cfg_div(i)) begin
            m_ticks[i] = 0;
            model_step(i);
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("model_delt%0d", i), int'(delt_w[i]), m_pos[i]);
      check($sformatf("model_dir%0d", i), int'(dir_w[i]), (m_heading[i] > 0) ? 0 : 1);
      check($sformatf("model_bounce%0d", i), int'(bounce_w[i]), m_bounce[i]);
      check($sformatf("model_state%0d", i), int'(state_w[i]), model_state(i));
    end
  end

  // ---------------- driver tasks ----------------
  int last_bounce0;

  // One frame_tick pulse followed by an idle cycle; bounce of u0 is
  // captured in the cycle right after the pulse edge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    last_bounce0 = int'(bounce_w[0]);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; enble = 1'b1; frame_tick = 1'b0;
    speed = 4'd4; max_delt = 11'd20;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_delt0", int'(delt_w[0]), 0);
    check("reset_dir0", int'(dir_w[0]), 0);
    check("reset_state0", int'(state_w[0]), 0);
    check("reset_bounce0", int'(bounce_w[0]), 0);

`ifndef LOGO_SCROLL_WRAP_EN
    // Rightward run to the limit.
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("run_r_delt_%0d", k), int'(delt_w[0]), 4 * k);
      check($sformatf("run_r_bounce_%0d", k), last_bounce0, (k == 5) ? 1 : 0);
      if (k == 2) check("div3_delt_t2", int'(delt_w[1]), 0);
      if (k == 3) check("div3_delt_t3", int'(delt_w[1]), 4);
    end
    check("hold_r_state", int'(state_w[0]), 2);
    // Two dwell steps at the right end.
    for (int k = 1; k <= 2; k++) begin
      tick();
      check($sformatf("hold_r_delt_%0d", k), int'(delt_w[0]), 20);
    end
    check("rev_dir", int'(dir_w[0]), 1);
    check("rev_state", int'(state_w[0]), 1);
    // Leftward run back to 0.
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("run_l_delt_%0d", k), int'(delt_w[0]), 20 - 4 * k);
      check($sformatf("run_l_bounce_%0d", k), last_bounce0, (k == 5) ? 1 : 0);
    end
    check("hold_l_state", int'(state_w[0]), 3);
    pulse_reset();
    check("rst_hold_delt", int'(delt_w[0]), 0);
    check("rst_hold_dir", int'(dir_w[0]), 0);
    check("rst_hold_state", int'(state_w[0]), 0);
    tick();
    check("after_rst_step", int'(delt_w[0]), 4);
`else
    speed = 4'd6;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("wrap_run_%0d", k), int'(delt_w[0]), 6 * k);
    end
    speed = 4'd7;
    tick();
    check("wrap_delt", int'(delt_w[0]), 4);
    check("wrap_bounce", last_bounce0, 1);
    check("wrap_dir", int'(dir_w[0]), 0);
    check("wrap_state", int'(state_w[0]), 0);
`endif

    // Freeze: ticks with enble=0 must not move anything.
    @(negedge clk) enble = 1'b0;
    repeat (10) tick();
    enble = 1'b1;

    // Randomized stimulus.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) enble = ~enble;
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) speed = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 9) == 0) max_delt = 11'($urandom_range(0, 2047));
        else max_delt = 11'($urandom_range(0, 120));
      end
    end
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
